// File: rtl/cl_frame_fmt_if.sv
// Pixel-buffer beat handshake feeding the Camera Link frame formatter.
// The source (pixel buffer) is master; the formatter is slave.
interface cl_frame_fmt_if;
    logic [63:0] in_data;
    logic        in_sof;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_sof, output in_valid, input in_ready);
    modport slave  (input in_data, input in_sof, input in_valid, output in_ready);
endinterface

// File: rtl/cl_frame_fmt.sv
// Camera Link frame formatter: pulls 8-tap pixel beats and emits registered fval/lval/dval
// and tap data with programmable line/frame geometry and blanking, in the clk_txg domain.
module cl_frame_fmt #(
    parameter int W_CNT    = 16,
    parameter int FV_LEAD  = 4,
    parameter int FV_TRAIL = 4
) (
    input  logic             clk_txg,
    input  logic             rst_tx_n,
    input  logic             enable,
    input  logic [W_CNT-1:0] line_beats,
    input  logic [W_CNT-1:0] frame_lines,
    input  logic [W_CNT-1:0] hblank,
    input  logic [W_CNT-1:0] vblank,
    cl_frame_fmt_if.slave    pix,
    output logic             fval,
    output logic             lval,
    output logic             dval,
    output logic [7:0]       chan_0,
    output logic [7:0]       chan_1,
    output logic [7:0]       chan_2,
    output logic [7:0]       chan_3,
    output logic [7:0]       chan_4,
    output logic [7:0]       chan_5,
    output logic [7:0]       chan_6,
    output logic [7:0]       chan_7,
    output logic             frame_done,
    output logic             sync_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        ACTIVE = 3'd2,
        HBLANK = 3'd3,
        TRAIL  = 3'd4,
        GAP    = 3'd5
    } state_t;

    localparam logic [W_CNT-1:0] ONE        = W_CNT'(1);
    localparam logic [W_CNT-1:0] LEAD_LAST  = W_CNT'(FV_LEAD - 1);
    localparam logic [W_CNT-1:0] TRAIL_LAST = W_CNT'(FV_TRAIL - 1);

    state_t           state, state_nxt;
    logic [W_CNT-1:0] phase_cnt, beat_cnt, line_cnt;
    logic [W_CNT-1:0] lb_r, fl_r, hb_r, vb_r;
    logic             start, accept, beat_last, line_last, first_beat, hb_done;
    logic             fval_p0, lval_p0, dval_p0, err_set, err_clr;
    logic [63:0]      data_p0;

    assign start      = (state == IDLE) && enable && pix.in_valid && pix.in_sof &&
                        (line_beats != '0) && (frame_lines != '0);
    assign accept     = pix.in_valid && pix.in_ready;
    assign beat_last  = (beat_cnt == lb_r - ONE);
    assign line_last  = (line_cnt == fl_r - ONE);
    assign first_beat = (beat_cnt == '0) && (line_cnt == '0);
    // A zero hblank still costs one lval-low cycle between lines.
    assign hb_done    = (hb_r == '0) || (phase_cnt == hb_r - ONE);

    always_ff @(posedge clk_txg or negedge rst_tx_n) begin
        if (!rst_tx_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            beat_cnt  <= '0;
            line_cnt  <= '0;
            lb_r      <= '0;
            fl_r      <= '0;
            hb_r      <= '0;
            vb_r      <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                phase_cnt <= '0;
            else if (state != ACTIVE && state != IDLE)
                phase_cnt <= phase_cnt + ONE;

            if (start) begin
                lb_r     <= line_beats;
                fl_r     <= frame_lines;
                hb_r     <= hblank;
                vb_r     <= vblank;
                beat_cnt <= '0;
                line_cnt <= '0;
            end else if (state == ACTIVE && accept) begin
                if (beat_last) begin
                    beat_cnt <= '0;
                    if (!line_last)
                        line_cnt <= line_cnt + ONE;
                end else begin
                    beat_cnt <= beat_cnt + ONE;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LEAD;
            LEAD:    if (phase_cnt == LEAD_LAST) state_nxt = ACTIVE;
            ACTIVE:  if (accept && beat_last) state_nxt = line_last ? TRAIL : HBLANK;
            HBLANK:  if (hb_done) state_nxt = ACTIVE;
            TRAIL:   if (phase_cnt == TRAIL_LAST) state_nxt = (vb_r == '0) ? IDLE : GAP;
            GAP:     if (phase_cnt == vb_r - ONE) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pix.in_ready = (state == ACTIVE) || ((state == IDLE) && pix.in_valid && !pix.in_sof);
        fval_p0      = (state == LEAD) || (state == ACTIVE) || (state == HBLANK) || (state == TRAIL);
        lval_p0      = (state == ACTIVE);
        dval_p0      = (state == ACTIVE) && accept;
        data_p0      = dval_p0 ? pix.in_data : 64'h0;
        // Stray beats in IDLE and a repeated sof inside a frame are both framing errors.
        err_set      = ((state == IDLE) && pix.in_valid && !pix.in_sof) ||
                       ((state == ACTIVE) && accept && pix.in_sof && !first_beat);
        err_clr      = (state == IDLE) && !enable;
    end

    // Output register stage: everything the serializer sees is one cycle behind the state.
    always_ff @(posedge clk_txg or negedge rst_tx_n) begin
        if (!rst_tx_n) begin
            fval       <= 1'b0;
            lval       <= 1'b0;
            dval       <= 1'b0;
            chan_0     <= 8'h0;
            chan_1     <= 8'h0;
            chan_2     <= 8'h0;
            chan_3     <= 8'h0;
            chan_4     <= 8'h0;
            chan_5     <= 8'h0;
            chan_6     <= 8'h0;
            chan_7     <= 8'h0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            fval       <= fval_p0;
            lval       <= lval_p0;
            dval       <= dval_p0;
            chan_0     <= data_p0[7:0];
            chan_1     <= data_p0[15:8];
            chan_2     <= data_p0[23:16];
            chan_3     <= data_p0[31:24];
            chan_4     <= data_p0[39:32];
            chan_5     <= data_p0[47:40];
            chan_6     <= data_p0[55:48];
            chan_7     <= data_p0[63:56];
            frame_done <= fval && !fval_p0;
            if (err_set)
                sync_err <= 1'b1;
            else if (err_clr)
                sync_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cl_frame_fmt.sv
// Randomized self-checking bench for cl_frame_fmt: frames are described as beat lists with
// per-beat stalls, and the expected output trace is built from the frame geometry rules.
module tb_cl_frame_fmt;
    localparam int W_CNT    = 16;
    localparam int FV_LEAD  = 4;
    localparam int FV_TRAIL = 4;

    logic             clk_txg  = 1'b0;
    logic             rst_tx_n = 1'b0;
    logic             enable   = 1'b0;
    logic [W_CNT-1:0] line_beats  = '0;
    logic [W_CNT-1:0] frame_lines = '0;
    logic [W_CNT-1:0] hblank      = '0;
    logic [W_CNT-1:0] vblank      = '0;
    logic             fval, lval, dval, frame_done, sync_err;
    logic [7:0]       chan_0, chan_1, chan_2, chan_3, chan_4, chan_5, chan_6, chan_7;

    cl_frame_fmt_if pix ();

    int   n_cmp   = 0;
    int   n_err   = 0;
    int   frm     = 0;
    logic exp_err = 1'b0;

    int          cfg_lb, cfg_fl, cfg_hb, cfg_vb;
    logic [63:0] beat_data[$];
    int          beat_dly[$];
    logic        beat_sof[$];
    logic [67:0] exp_q[$];

    always #5 clk_txg = ~clk_txg;

    cl_frame_fmt #(.W_CNT(W_CNT), .FV_LEAD(FV_LEAD), .FV_TRAIL(FV_TRAIL)) dut (
        .clk_txg(clk_txg), .rst_tx_n(rst_tx_n), .enable(enable),
        .line_beats(line_beats), .frame_lines(frame_lines), .hblank(hblank), .vblank(vblank),
        .pix(pix.slave),
        .fval(fval), .lval(lval), .dval(dval),
        .chan_0(chan_0), .chan_1(chan_1), .chan_2(chan_2), .chan_3(chan_3),
        .chan_4(chan_4), .chan_5(chan_5), .chan_6(chan_6), .chan_7(chan_7),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [67:0] obs();
        return {frame_done, fval, lval, dval, chan_7, chan_6, chan_5, chan_4,
                chan_3, chan_2, chan_1, chan_0};
    endfunction

    function automatic logic [67:0] ent(input logic fd, input logic fv, input logic lv,
                                        input logic dv, input logic [63:0] d);
        return {fd, fv, lv, dv, d};
    endfunction

    task automatic setup_frame(input int lb, input int fl, input int hb, input int vb);
        cfg_lb = lb; cfg_fl = fl; cfg_hb = hb; cfg_vb = vb;
        @(negedge clk_txg);
        line_beats  = W_CNT'(lb);
        frame_lines = W_CNT'(fl);
        hblank      = W_CNT'(hb);
        vblank      = W_CNT'(vb);
        enable      = 1'b1;
    endtask

    task automatic build_frame(input int stall_max, input logic sof_err);
        beat_data.delete(); beat_dly.delete(); beat_sof.delete();
        for (int l = 0; l < cfg_fl; l++) begin
            for (int b = 0; b < cfg_lb; b++) begin
                beat_data.push_back({$urandom, $urandom});
                beat_dly.push_back((b == 0) ? 0 : int'($urandom_range(0, stall_max)));
                beat_sof.push_back((l == 0 && b == 0) ? 1'b1 :
                                   (sof_err && ($urandom_range(0, 3) == 0)));
            end
        end
    endtask

    // Expected per-cycle trace from the first fval-high cycle through the frame_done cycle.
    task automatic make_expected();
        int idx;
        idx = 0;
        exp_q.delete();
        repeat (FV_LEAD) exp_q.push_back(ent(0, 1, 0, 0, 64'h0));
        for (int l = 0; l < cfg_fl; l++) begin
            if (l > 0) repeat ((cfg_hb == 0) ? 1 : cfg_hb) exp_q.push_back(ent(0, 1, 0, 0, 64'h0));
            for (int b = 0; b < cfg_lb; b++) begin
                repeat (beat_dly[idx]) exp_q.push_back(ent(0, 1, 1, 0, 64'h0));
                exp_q.push_back(ent(0, 1, 1, 1, beat_data[idx]));
                if (beat_sof[idx] && idx != 0) exp_err = 1'b1;
                idx++;
            end
        end
        repeat (FV_TRAIL) exp_q.push_back(ent(0, 1, 0, 0, 64'h0));
        exp_q.push_back(ent(1, 0, 0, 0, 64'h0));
    endtask

    task automatic drive_frame();
        logic acc;
        int   n;
        for (int i = 0; i < beat_data.size(); i++) begin
            repeat (beat_dly[i]) begin
                @(negedge clk_txg);
                pix.in_valid = 1'b0;
                pix.in_sof   = 1'b0;
            end
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 500) begin
                @(negedge clk_txg);
                pix.in_valid = 1'b1;
                pix.in_data  = beat_data[i];
                pix.in_sof   = beat_sof[i];
                #4;
                acc = pix.in_ready;
                n++;
                @(posedge clk_txg);
            end
            if (!acc) chk($sformatf("frame%0d_handshake_timeout", frm), 68'(acc), 68'd1);
        end
        @(negedge clk_txg);
        pix.in_valid = 1'b0;
        pix.in_sof   = 1'b0;
    endtask

    task automatic mon_frame();
        int n;
        n = 0;
        @(negedge clk_txg);
        while (!fval && n < 300) begin
            @(negedge clk_txg);
            n++;
        end
        if (!fval) begin
            chk($sformatf("frame%0d_fval_rise", frm), 68'(fval), 68'd1);
        end else begin
            // Geometry inputs are latched at frame start; disturbing them must not matter.
            line_beats  = W_CNT'($urandom);
            frame_lines = W_CNT'($urandom);
            hblank      = W_CNT'($urandom);
            vblank      = W_CNT'($urandom);
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) @(negedge clk_txg);
                chk($sformatf("frame%0d_cyc%0d", frm, i), obs(), exp_q[i]);
            end
        end
    endtask

    task automatic exec_frame();
        make_expected();
        fork
            drive_frame();
            mon_frame();
        join
        @(negedge clk_txg);
        chk($sformatf("frame%0d_sync_err", frm), 68'(sync_err), 68'(exp_err));
        frm++;
    endtask

    task automatic clear_err();
        @(negedge clk_txg);
        enable = 1'b0;
        repeat (8) @(negedge clk_txg);
        chk("sync_err_clear", 68'(sync_err), 68'd0);
        exp_err = 1'b0;
        enable  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim_time got=expired want=done");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        pix.in_valid = 1'b0;
        pix.in_sof   = 1'b0;
        pix.in_data  = 64'h0;

        repeat (3) @(negedge clk_txg);
        chk("rst_outputs", obs(), 68'd0);
        chk("rst_sync_err", 68'(sync_err), 68'd0);
        chk("rst_ready", 68'(pix.in_ready), 68'd0);
        @(negedge clk_txg);
        rst_tx_n = 1'b1;

        // Zero geometry: sof beat waits, nothing consumed, no frame.
        setup_frame(0, 2, 1, 1);
        pix.in_valid = 1'b1;
        pix.in_sof   = 1'b1;
        pix.in_data  = {$urandom, $urandom};
        #4;
        chk("zero_geom_ready", 68'(pix.in_ready), 68'd0);
        repeat (5) begin
            @(negedge clk_txg);
            chk("zero_geom_fval", 68'(fval), 68'd0);
        end
        pix.in_valid = 1'b0;
        pix.in_sof   = 1'b0;

        // Continuous 4x2 frame, then the same with a 2-cycle underrun in line 1.
        setup_frame(4, 2, 3, 2);
        build_frame(0, 1'b0);
        exec_frame();
        setup_frame(4, 2, 3, 2);
        build_frame(0, 1'b0);
        beat_dly[5] = 2;
        exec_frame();

        // Repeated sof on beat 2 of line 0.
        setup_frame(4, 2, 3, 2);
        build_frame(0, 1'b0);
        beat_sof[2]  = 1'b1;
        beat_data[2] = 64'h0706050403020100;
        exec_frame();
        clear_err();

        // Minimal geometry and zero hblank.
        setup_frame(1, 1, 0, 0);
        build_frame(0, 1'b0);
        exec_frame();
        setup_frame(2, 3, 0, 1);
        build_frame(1, 1'b0);
        exec_frame();

        // Stray beat while idle.
        repeat (8) @(negedge clk_txg);
        pix.in_valid = 1'b1;
        pix.in_sof   = 1'b0;
        pix.in_data  = {$urandom, $urandom};
        #4;
        chk("idle_discard_ready", 68'(pix.in_ready), 68'd1);
        @(negedge clk_txg);
        pix.in_valid = 1'b0;
        chk("idle_discard_err", 68'(sync_err), 68'd1);
        exp_err = 1'b1;
        repeat (3) begin
            @(negedge clk_txg);
            chk("idle_discard_fval", 68'(fval), 68'd0);
        end
        clear_err();

        // Asynchronous reset in the middle of a line.
        setup_frame(4, 2, 2, 1);
        pix.in_valid = 1'b1;
        pix.in_sof   = 1'b1;
        pix.in_data  = {$urandom, $urandom};
        @(negedge clk_txg);
        pix.in_sof = 1'b0;
        n = 0;
        while (!lval && n < 50) begin
            @(negedge clk_txg);
            n++;
        end
        chk("rst_mid_lval", 68'(lval), 68'd1);
        #2 rst_tx_n = 1'b0;
        #1 chk("rst_mid_outputs", obs(), 68'd0);
        pix.in_valid = 1'b0;
        @(negedge clk_txg);
        rst_tx_n = 1'b1;
        repeat (4) begin
            @(negedge clk_txg);
            chk("post_rst_idle", 68'({fval, lval, dval}), 68'd0);
        end

        // Random geometry, stalls and stray sofs.
        for (int f = 0; f < 12; f++) begin
            setup_frame($urandom_range(1, 6), $urandom_range(1, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            build_frame($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
            exec_frame();
            if (exp_err) clear_err();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
